// File: rtl/ppu_pkg.sv
// Shared constants and fixed-point helpers for the posit divider datapath.
// Mantissa width default, reciprocal-seed coefficients and derived format widths.
// No logic here; everything is evaluated at elaboration.
package ppu_pkg;

  // Default mantissa width including the hidden bit.
  localparam int N = 14;

  // Seed coefficient numerators over the common denominator 17.
  localparam int SEED_C0_NUM = 24;
  localparam int SEED_C1_NUM = 8;
  localparam int SEED_DEN    = 17;

  // floor(numer/17 * 2^frac_bits), i.e. the coefficient in a format with
  // frac_bits fractional bits, truncated toward zero.
  function automatic logic [127:0] seed_coef(input int numer, input int frac_bits);
    logic [127:0] scaled;
    scaled = 128'(numer) << frac_bits;
    return scaled / 128'(SEED_DEN);
  endfunction

  // Seed reciprocal width: Q1.(3m-5).
  function automatic int x0_width(input int mant_size);
    return 3 * mant_size - 4;
  endfunction

  // Refined reciprocal width: Q1.(2m-1).
  function automatic int x1_width(input int mant_size);
    return 2 * mant_size;
  endfunction

endpackage

// File: rtl/recip_seed.sv
// Linear-minimax seed reciprocal x0 = 24/17 - 8/17*num, exact 1.0 for num == 1.0.
// Latency: purely combinational.
// Backpressure: none; output follows the input continuously.
module recip_seed
  import ppu_pkg::*;
#(
  parameter int MANT_SIZE = N
) (
  input  logic [MANT_SIZE-1:0]           num_i,
  output logic [x0_width(MANT_SIZE)-1:0] x0_o
);

  localparam int XW = x0_width(MANT_SIZE);
  localparam int FX = XW - 1;           // fractional bits of x0
  localparam int PW = XW + MANT_SIZE;   // C1*num full product width

  localparam logic [127:0]  C0_FULL = seed_coef(SEED_C0_NUM, FX);
  localparam logic [127:0]  C1_FULL = seed_coef(SEED_C1_NUM, FX);
  localparam logic [XW-1:0] C0      = C0_FULL[XW-1:0];
  localparam logic [XW-1:0] C1      = C1_FULL[XW-1:0];
  localparam logic [XW-1:0] ONE     = {1'b1, {(XW-1){1'b0}}};

  logic [PW-1:0] c1_num;
  logic [XW-1:0] c1_num_trunc;
  logic          is_one;
  logic          unused_prod_hi;

  // C1 (Q.FX) times num (Q1.(MANT_SIZE-1)) has FX+MANT_SIZE-1 fraction bits;
  // dropping the low MANT_SIZE-1 bits truncates it back to the x0 format.
  assign c1_num         = PW'(C1) * PW'(num_i);
  assign c1_num_trunc   = c1_num[MANT_SIZE-1 +: XW];
  assign unused_prod_hi = ^{c1_num[PW-1:MANT_SIZE-1+XW], c1_num[MANT_SIZE-2:0]};

  assign is_one = ~|num_i[MANT_SIZE-2:0];

  // Seed select: the linear fit is not exact at 1.0, so that point is forced.
  always_comb begin
    x0_o = C0 - c1_num_trunc;
    if (is_one) begin
      x0_o = ONE;
    end
  end

endmodule

// File: rtl/mant_recip_nr.sv
// Mantissa reciprocal: seed + one Newton-Raphson step, x1 = x0*(2 - num*x0).
// Latency: x0_o combinational, x1_o one cycle after num_i is sampled.
// Backpressure: none; fully pipelined, accepts a new mantissa every cycle.
module mant_recip_nr
  import ppu_pkg::*;
#(
  parameter int MANT_SIZE = N
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [MANT_SIZE-1:0]           num_i,
  output logic [x0_width(MANT_SIZE)-1:0] x0_o,
  output logic [x1_width(MANT_SIZE)-1:0] x1_o
);

  localparam int XW  = x0_width(MANT_SIZE);   // Q1.(3m-5)
  localparam int X1W = x1_width(MANT_SIZE);   // Q1.(2m-1)
  localparam int YW  = MANT_SIZE + XW;        // num*x0, Q2.(4m-6)
  localparam int PW  = XW + YW;               // x0*e, Q3.(7m-11)
  // Fraction bits of p minus fraction bits of x1.
  localparam int SH  = (XW - 1 + YW - 2) - (X1W - 1);

  localparam logic [YW-1:0]  TWO     = {2'b10, {(YW-2){1'b0}}};
  localparam logic [X1W-1:0] X1_ONE  = {1'b1, {(X1W-1){1'b0}}};

  logic [XW-1:0]        x0_seed;
  logic [MANT_SIZE-1:0] num_d, num_q;
  logic [XW-1:0]        x0_d, x0_q;
  logic                 one_d, one_q;

  logic [YW-1:0]        y;
  logic [YW-1:0]        e;
  logic [PW-1:0]        p;
  logic                 unused_p_bits;

  recip_seed #(
    .MANT_SIZE(MANT_SIZE)
  ) u_seed (
    .num_i(num_i),
    .x0_o (x0_seed)
  );

  assign x0_o = x0_seed;

  // Next-state for the single pipeline stage: mantissa, seed and exact-one flag.
  always_comb begin
    num_d = num_i;
    x0_d  = x0_seed;
    one_d = ~|num_i[MANT_SIZE-2:0];
  end

  // Pipeline register; reset clears it so x1_o reads 0 until the first edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_q <= '0;
      x0_q  <= '0;
      one_q <= 1'b0;
    end else begin
      num_q <= num_d;
      x0_q  <= x0_d;
      one_q <= one_d;
    end
  end

  // Newton step at full width; e stays near 1 for in-range mantissas, and
  // out-of-range inputs simply wrap without producing unknowns.
  assign y = YW'(num_q) * YW'(x0_q);
  assign e = TWO - y;
  assign p = PW'(x0_q) * PW'(e);

  assign unused_p_bits = ^{p[PW-1:SH+X1W], p[SH-1:0]};

  // Output select: plain truncation, except 1.0 which must be exact.
  always_comb begin
    x1_o = p[SH +: X1W];
    if (one_q) begin
      x1_o = X1_ONE;
    end
  end

endmodule

// File: tb/tb_mant_recip_nr.sv
// Self-checking bench for mant_recip_nr at MANT_SIZE = 8.
// Hand-computed vector table, reset and streaming sequences, exhaustive sweep.
// Inputs driven on the falling edge, outputs sampled 1 time unit after edges.
module tb_mant_recip_nr;

  localparam int M = 8;

  logic        clk_i;
  logic        rst_ni;
  logic [7:0]  num_i;
  logic [19:0] x0_o;
  logic [15:0] x1_o;

  int checks;
  int errors;

  typedef struct {
    logic [7:0]  num;
    logic [19:0] x0;
    logic [15:0] x1;
  } vec_t;

  vec_t tbl[5];

  mant_recip_nr #(
    .MANT_SIZE(M)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .num_i (num_i),
    .x0_o  (x0_o),
    .x1_o  (x1_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden arithmetic: independent integer evaluation of the seed and NR step.
  function automatic void golden(input logic [7:0] n, output logic [19:0] gx0,
                                 output logic [15:0] gx1);
    longint unsigned c0, c1, x0v, y, e, p, q;
    c0 = (longint'(24) << 19) / 17;
    c1 = (longint'(8) << 19) / 17;
    if (n[6:0] == 7'd0) begin
      gx0 = 20'h80000;
      gx1 = 16'h8000;
    end else begin
      x0v = c0 - ((c1 * longint'(n)) >> 7);
      y   = longint'(n) * x0v;
      e   = (longint'(1) << 27) - y;
      p   = x0v * e;
      q   = p >> 30;
      gx0 = x0v[19:0];
      gx1 = q[15:0];
    end
  endfunction

  // Accuracy window (0.4%) and the never-above-1/num bound, in integer form:
  // x1*num is compared against 2^22 (= 1.0 in Q1.15 * Q1.7).
  task automatic check_accuracy(input string name, input logic [7:0] n, input logic [15:0] x1);
    longint prod, diff;
    prod = longint'(x1) * longint'(n);
    diff = 64'sd4194304 - prod;
    checks++;
    if (diff < 0 || diff > 16777) begin
      errors++;
      $display("FAIL %s: num 0x%0h x1 0x%0h x1*num %0d required in [%0d,4194304]",
               name, n, x1, prod, 4194304 - 16777);
    end
  endtask

  // Drive one mantissa, check the seed combinationally, then the refined result.
  task automatic step(input string name, input logic [7:0] n, input logic [19:0] ex0,
                      input logic [15:0] ex1);
    @(negedge clk_i);
    num_i = n;
    #1;
    check({name, "_x0"}, 64'(x0_o), 64'(ex0));
    @(posedge clk_i);
    #1;
    check({name, "_x1"}, 64'(x1_o), 64'(ex1));
  endtask

  initial begin
    logic [19:0] gx0;
    logic [15:0] gx1;
    checks = 0;
    errors = 0;

    tbl[0] = '{num: 8'h80, x0: 20'h80000, x1: 16'h8000};
    tbl[1] = '{num: 8'hA0, x0: 20'h69698, x1: 16'h664F};
    tbl[2] = '{num: 8'hC0, x0: 20'h5A5A7, x1: 16'h5509};
    tbl[3] = '{num: 8'hE0, x0: 20'h4B4B6, x1: 16'h4914};
    tbl[4] = '{num: 8'hFF, x0: 20'h3CB4D, x1: 16'h400E};

    // Reset held: output must stay 0 across edges.
    rst_ni = 1'b0;
    num_i  = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      check("reset_hold_x1", 64'(x1_o), 64'h0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("reset_release_x1", 64'(x1_o), 64'h5509);

    // Hand-computed vectors.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("vec%0d", i), tbl[i].num, tbl[i].x0, tbl[i].x1);
      check_accuracy($sformatf("vec%0d_acc", i), tbl[i].num, x1_o);
    end

    // Streaming on consecutive cycles, results in order.
    for (int i = 0; i < 4; i++) begin
      step($sformatf("stream%0d", i), tbl[i].num, tbl[i].x0, tbl[i].x1);
    end

    // Mid-stream asynchronous reset drops the in-flight value.
    @(negedge clk_i);
    num_i = 8'hFF;
    @(posedge clk_i);
    #1;
    check("pre_reset_x1", 64'(x1_o), 64'h400E);
    @(negedge clk_i);
    num_i  = 8'hA0;
    rst_ni = 1'b0;
    #1;
    check("async_reset_x1", 64'(x1_o), 64'h0);
    @(posedge clk_i);
    #1;
    check("in_reset_edge_x1", 64'(x1_o), 64'h0);
    @(negedge clk_i);
    num_i  = 8'hE0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_reset_x1", 64'(x1_o), 64'h4914);

    // Exhaustive sweep of legal mantissas against the golden model.
    for (int n = 128; n < 256; n++) begin
      golden(8'(n), gx0, gx1);
      step($sformatf("sweep_%0h", n), 8'(n), gx0, gx1);
      check_accuracy($sformatf("sweep_acc_%0h", n), 8'(n), x1_o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
